// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch front end.
// Issues word fetches over a req/ack handshake, buffers {instr, pc} in a
// small FIFO and presents the head with pre-sliced decode fields. A redirect
// flushes the queue; a fetch still in flight is completed and its data dropped.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [6:0]  op_o,
    output logic [2:0]  funct3_o,
    output logic        funct7_5_o
);

    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);
    localparam logic [31:0]    NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     tgt_q, tgt_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     instr_mem_q [DEPTH];
    logic [31:0]     pc_mem_q    [DEPTH];

    logic            push;
    logic            pop;
    logic [31:0]     redir_pc;
    logic            head_valid;

    // Next-state for FSM, fetch PC, saved redirect target and FIFO bookkeeping.
    always_comb begin
        redir_pc   = redirect_pc_i & 32'hFFFF_FFFC;
        push       = (state_q == REQ) && imem_ack_i && !redirect_i;
        pop        = (count_q != '0) && instr_ready_i && !redirect_i;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        tgt_d      = tgt_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        // Flush dominates any push/pop in the same cycle.
        if (redirect_i) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
            rd_ptr_d = rd_ptr_q + PW'(pop);
        end

        case (state_q)
            HOLD: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    state_d    = REQ;
                end else if (count_d < FULL) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_i) begin
                    if (imem_ack_i) begin
                        fetch_pc_d = redir_pc;
                    end else begin
                        tgt_d   = redir_pc;
                        state_d = DISCARD;
                    end
                end else if (imem_ack_i) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = (count_d < FULL) ? REQ : HOLD;
                end
            end
            DISCARD: begin
                // In-flight data is dropped; the newest target wins.
                if (imem_ack_i) begin
                    fetch_pc_d = redirect_i ? redir_pc : tgt_q;
                    state_d    = REQ;
                end else if (redirect_i) begin
                    tgt_d = redir_pc;
                end
            end
            default: state_d = REQ;
        endcase
    end

    // Control state; reset abandons any outstanding request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            tgt_q      <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            tgt_q      <= tgt_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata_i;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

    // Head presentation: empty queue shows a NOP at the current fetch PC.
    always_comb begin
        head_valid    = (count_q != '0);
        instr_valid_o = head_valid;
        instr_o       = head_valid ? instr_mem_q[rd_ptr_q] : NOP;
        pc_o          = head_valid ? pc_mem_q[rd_ptr_q] : fetch_pc_q;
        op_o          = instr_o[6:0];
        funct3_o      = instr_o[14:12];
        funct7_5_o    = instr_o[30];
        imem_req_o    = (state_q != HOLD) && !rst_i;
        imem_addr_o   = fetch_pc_q;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus a randomized run.
// Reference: the delivered stream after reset/redirect to T must be T, T+4, ...
// with each word equal to a known function of its address; the bus must hold
// a pending request and its address until ack.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [6:0]  op_o;
    logic [2:0]  funct3_o;
    logic        funct7_5_o;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .op_o         (op_o),
        .funct3_o     (funct3_o),
        .funct7_5_o   (funct7_5_o)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          pops     = 0;
    logic [31:0] exp_pc;
    logic [31:0] key;
    int          waits, fix_waits, wcnt;
    bit          rnd;
    bit          pend;
    logic [31:0] pend_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory response, check bus protocol and delivered stream.
    task automatic step();
        logic        req_s, ack_s;
        logic [31:0] ew;
        imem_ack_i   = imem_req_o && (wcnt >= waits);
        imem_rdata_i = imem_addr_o ^ key;
        if (pend) begin
            chk("req_held", {31'b0, imem_req_o}, 32'd1);
            chk("addr_held", imem_addr_o, pend_addr);
        end
        if (redirect_i) begin
            exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
        end else if (instr_valid_o && instr_ready_i) begin
            ew = exp_pc ^ key;
            chk("pop_pc", pc_o, exp_pc);
            chk("pop_instr", instr_o, ew);
            chk("pop_fields", {20'b0, funct7_5_o, funct3_o, op_o}, {20'b0, ew[30], ew[14:12], ew[6:0]});
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        req_s     = imem_req_o;
        ack_s     = imem_ack_i;
        pend_addr = imem_addr_o;
        @(posedge clk); #1;
        if (req_s && ack_s) begin
            wcnt  = 0;
            waits = rnd ? int'($urandom_range(0, 3)) : fix_waits;
        end else if (req_s) begin
            wcnt++;
        end
        pend = req_s && !ack_s;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        redirect_i = 1'b0;
        imem_ack_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);
        pend   = 1'b0;
        wcnt   = 0;
        waits  = fix_waits;
        exp_pc = 32'h0;
        rst_i  = 1'b0;
        #1;
        chk("rst_req_after", {31'b0, imem_req_o}, 32'd1);
        chk("rst_addr", imem_addr_o, 32'h0);
    endtask

    initial begin
        rst_i = 1'b1; imem_ack_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b1;
        key = 32'h0; rnd = 1'b0; fix_waits = 0; waits = 0; wcnt = 0; pend = 1'b0;
        exp_pc = 32'h0; pend_addr = '0;

        // Streaming with zero-wait memory, word = address.
        do_reset();
        step();
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", {31'b0, instr_valid_o}, 32'd1);
            chk("stream_pc", pc_o, 32'(4 * i));
            step();
        end

        // Backpressure: queue fills to 4 and request drops.
        instr_ready_i = 1'b0;
        do_reset();
        repeat (10) step();
        chk("bp_req_low", {31'b0, imem_req_o}, 32'd0);
        chk("bp_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("bp_head", pc_o, 32'h0);
        instr_ready_i = 1'b1;
        step();
        chk("bp_resume_req", {31'b0, imem_req_o}, 32'd1);
        chk("bp_resume_addr", imem_addr_o, 32'h10);
        chk("bp_drain1", pc_o, 32'h4);
        step();
        chk("bp_drain2", pc_o, 32'h8);
        step();
        chk("bp_drain3", pc_o, 32'hC);
        step();
        chk("bp_next", pc_o, 32'h10);

        // Redirect during wait states: old request completes, data dropped.
        fix_waits = 3;
        do_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rif_addr_hold", imem_addr_o, 32'h0);
            chk("rif_valid", {31'b0, instr_valid_o}, 32'd0);
            step();
        end
        chk("rif_new_addr", imem_addr_o, 32'h100);
        chk("rif_dropped", {31'b0, instr_valid_o}, 32'd0);
        for (int i = 0; i < 20 && !instr_valid_o; i++) step();
        chk("rif_first_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("rif_first_pc", pc_o, 32'h100);

        // Double redirect while discarding: newest target wins.
        do_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        step();
        redirect_pc_i = 32'h300;
        step();
        redirect_i = 1'b0;
        chk("dbl_addr_hold", imem_addr_o, 32'h0);
        step();
        step();
        chk("dbl_new_addr", imem_addr_o, 32'h300);
        for (int i = 0; i < 20 && !instr_valid_o; i++) step();
        chk("dbl_first_pc", pc_o, 32'h300);

        // Redirect coincident with ack and pop.
        fix_waits = 0;
        do_reset();
        repeat (3) step();
        chk("co_pre_valid", {31'b0, instr_valid_o}, 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h400;
        step();
        redirect_i = 1'b0;
        chk("co_valid_flushed", {31'b0, instr_valid_o}, 32'd0);
        chk("co_addr", imem_addr_o, 32'h400);
        step();
        chk("co_first_pc", pc_o, 32'h400);

        // Misaligned target near the top of the address space wraps.
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        step();
        redirect_i = 1'b0;
        chk("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr1", imem_addr_o, 32'h0);
        chk("wrap_head", pc_o, 32'hFFFF_FFFC);
        step();
        chk("wrap_head2", pc_o, 32'h0);

        // Randomized waits, stalls and redirects against the stream model.
        rnd = 1'b1;
        key = 32'h5A3C_96E1;
        do_reset();
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready_i = ($urandom_range(0, 3) != 0);
            redirect_i    = ($urandom_range(0, 15) == 0);
            redirect_pc_i = $urandom;
            step();
        end
        redirect_i = 1'b0;
        chk("rand_progress", {31'b0, pops > 300}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
